studio2_mem_arbiter: RTL and testbench
======================================

Name: studio2_mem_arbiter

Overview:
- Sequences the single shared system-RAM port (12-bit address, 8-bit data, registered read, 1-cycle latency) between three requesters: the ROM/cart loader, the CDP1802 CPU bus and the Pixie video DMA fetch.
- Performs the Studio II address decode: ROM/cart write protect, RAM mirror at C00-DFF, and unmapped-read return.
- Generates the post-download CPU hold.

Parameters:
- DMA_BURST, 8, maximum consecutive DMA grants while a CPU request is pending.
- HOLD_CYCLES, 1024, number of cycles cpu_hold stays high after reset release or loader completion.
- CART_BASE, 12'h400, load offset applied when dl_index != 0.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- dl_active  in  1  loader download in progress
- dl_wr  in  1  loader write strobe, one cycle
- dl_index  in  8  loader image index; 0 = system ROM, other values = cartridge
- dl_addr  in  12  loader byte address
- dl_data  in  8  loader byte
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  CPU write (1) / read (0), valid with cpu_req
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  CPU read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_hold  out  1  CPU clear request (drives CLEAR_N low externally)
- dma_req  in  1  video fetch request, held until dma_ack
- dma_addr  in  12  video fetch address
- dma_rdata  out  8  fetched byte, valid with dma_ack
- dma_ack  out  1  one-cycle completion pulse
- mem_addr  out  12  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data, valid the cycle after the address

Behaviour:

Reset values:
- reset_n low asynchronously forces state IDLE.
- mem_we=0, mem_addr=0, mem_wdata=0.
- cpu_ack=0, dma_ack=0, cpu_rdata=8'hFF, dma_rdata=0.
- cpu_hold=1; hold counter=HOLD_CYCLES; DMA burst counter=0.

Hold:
- After reset release, cpu_hold stays 1 for HOLD_CYCLES cycles, then drops to 0.
- A falling edge of dl_active reloads the counter and sets cpu_hold=1 again.
- cpu_hold is also 1 throughout dl_active.

FSM states IDLE, ACCESS, RESP, LOAD:
- IDLE: if dl_active, go to LOAD. Otherwise grant one request per the priority rules and go to ACCESS, with mem_addr/mem_we/mem_wdata registered for that access.
- ACCESS: RAM address is presented; go to RESP.
- RESP: capture mem_rdata into cpu_rdata or dma_rdata and pulse the granted ack. If another eligible request is pending, grant it directly (go to ACCESS); else go to IDLE.
  - The requester being acked is excluded from arbitration in its ack cycle.
  - A req still high the cycle after its ack is a new request.
- Latency: request seen in IDLE at edge N gives ack high in cycle N+2. Back-to-back service yields one access every 2 cycles.

Priority:
- Loader first, then DMA, then CPU.
- After DMA_BURST consecutive DMA grants with cpu_req pending, the next grant goes to the CPU.
- The burst counter clears on any CPU grant or when dma_req is low.

CPU decode (all accesses complete with ack):
- cpu_addr[15:12] != 0: no RAM cycle, mem_we stays 0, read returns 8'hFF.
- 000-7FF, A00-BFF, E00-FFF: read from RAM. Writes are dropped (mem_we=0).
- 800-9FF: read/write.
- C00-DFF: folded to 800-9FF (addr[10]=0), read/write.

DMA:
- dma_addr is used unmodified, read-only.

LOAD:
- The RAM port follows the loader combinationally: mem_we=dl_wr, mem_addr=dl_addr+(dl_index!=0 ? CART_BASE : 0), mem_wdata=dl_data.
- A write whose un-truncated sum is >= 12'h1000 is dropped.
- No acks are issued during LOAD.
- When dl_active goes low, return to IDLE.

dl_active rising mid-operation:
- Any in-flight ACCESS or RESP is aborted without ack, and the state moves to LOAD the next cycle.
- Requesters keep req high, so the aborted access is re-issued after LOAD.

Test Plan:
1. Reset release, no requests -> cpu_hold=1 for exactly 1024 cycles, then 0; mem_we=0 throughout.
2. dl_index=1, dl_addr=12'h010, dl_data=8'h5A, dl_wr pulse -> mem_addr=12'h410, mem_we=1 same cycle. dl_index=1, dl_addr=12'hC00 -> no write. dl_active fall -> cpu_hold high for 1024 cycles.
3. CPU write 8'hA5 to 16'h0C23, then CPU read 16'h0823 -> mem_addr=12'h823 on both accesses; read returns 8'hA5 with ack 2 cycles after request.
4. CPU write to 16'h0100 -> ack pulses, mem_we stays 0. CPU read of 16'h1234 -> ack with cpu_rdata=8'hFF, no RAM cycle.
5. dma_req held continuously plus cpu_req -> exactly 8 DMA acks, then one CPU ack, then DMA resumes.
6. dl_active rises while a CPU read is in ACCESS -> no cpu_ack. After dl_active falls, the read is re-issued and acked with correct data.

Source files
------------

// File: rtl/studio2_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : studio2_mem_arbiter
// Brief    : Shares the Studio II system-RAM port between loader, CPU and DMA.
// Revision : 1.0 - initial release
// ============================================================================
module studio2_mem_arbiter #(
    parameter int          DMA_BURST   = 8,
    parameter int          HOLD_CYCLES = 1024,
    parameter logic [11:0] CART_BASE   = 12'h400
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [7:0]  dl_index,
    input  logic [11:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_hold,
    input  logic        dma_req,
    input  logic [11:0] dma_addr,
    output logic [7:0]  dma_rdata,
    output logic        dma_ack,
    output logic [11:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int BURST_W = $clog2(DMA_BURST + 1);
    localparam logic [HOLD_W-1:0]  c_hold_load = HOLD_W'(HOLD_CYCLES);
    localparam logic [BURST_W-1:0] c_burst_max = BURST_W'(DMA_BURST);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_LOAD   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic                 r_dl_active_d;
    logic [BURST_W-1:0]   r_burst_cnt;
    logic                 r_gnt_cpu;
    logic                 r_ram_ok;
    logic [11:0]          r_mem_addr;
    logic                 r_mem_we;
    logic [7:0]           r_mem_wdata;
    logic [7:0]           r_cpu_rdata;
    logic [7:0]           r_dma_rdata;

    logic                 w_cpu_mapped;
    logic                 w_cpu_writable;
    logic [11:0]          w_cpu_ram_addr;
    logic [12:0]          w_ld_sum;
    logic                 w_arb_ok;
    logic                 w_cpu_elig;
    logic                 w_dma_elig;
    logic                 w_burst_full;
    logic                 w_grant_cpu;
    logic                 w_grant_dma;
    logic                 w_resp_live;
    logic [7:0]           w_cpu_rd;

    // Writable window is 800-9FF plus its C00-DFF mirror; the mirror clears A10.
    assign w_cpu_mapped   = (cpu_addr[15:12] == 4'h0);
    assign w_cpu_writable = cpu_addr[11] & ~cpu_addr[9];
    assign w_cpu_ram_addr = {cpu_addr[11], cpu_addr[10] & ~w_cpu_writable, cpu_addr[9:0]};

    assign w_ld_sum = {1'b0, dl_addr} + {1'b0, ((dl_index != 8'd0) ? CART_BASE : 12'h000)};

    // A pending DMA request blocks the CPU until the burst allowance runs out,
    // even in the RESP cycle where the DMA itself is not re-granted.
    assign w_arb_ok     = ((r_state == ST_IDLE) || (r_state == ST_RESP)) && !dl_active;
    assign w_cpu_elig   = cpu_req && !((r_state == ST_RESP) && r_gnt_cpu);
    assign w_dma_elig   = dma_req && !((r_state == ST_RESP) && !r_gnt_cpu);
    assign w_burst_full = (r_burst_cnt >= c_burst_max);
    assign w_grant_cpu  = w_arb_ok && w_cpu_elig && (!dma_req || w_burst_full);
    assign w_grant_dma  = w_arb_ok && w_dma_elig && !w_grant_cpu;

    assign w_resp_live = (r_state == ST_RESP) && !dl_active;
    assign cpu_ack     = w_resp_live && r_gnt_cpu;
    assign dma_ack     = w_resp_live && !r_gnt_cpu;
    assign w_cpu_rd    = r_ram_ok ? mem_rdata : 8'hFF;
    assign cpu_rdata   = cpu_ack ? w_cpu_rd : r_cpu_rdata;
    assign dma_rdata   = dma_ack ? mem_rdata : r_dma_rdata;

    assign cpu_hold = (r_hold_cnt != '0) | dl_active | r_dl_active_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_addr    = r_mem_addr;
        mem_we      = r_mem_we;
        mem_wdata   = r_mem_wdata;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (dl_active) begin
                    w_state_nxt = ST_LOAD;
                end else if (w_grant_cpu || w_grant_dma) begin
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: w_state_nxt = dl_active ? ST_LOAD : ST_RESP;
            ST_LOAD: begin
                mem_addr  = w_ld_sum[11:0];
                mem_we    = dl_wr & ~w_ld_sum[12];
                mem_wdata = dl_data;
                if (!dl_active) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_cnt    <= c_hold_load;
            r_dl_active_d <= 1'b0;
            r_burst_cnt   <= '0;
            r_gnt_cpu     <= 1'b0;
            r_ram_ok      <= 1'b0;
            r_mem_addr    <= 12'h000;
            r_mem_we      <= 1'b0;
            r_mem_wdata   <= 8'h00;
            r_cpu_rdata   <= 8'hFF;
            r_dma_rdata   <= 8'h00;
        end else begin
            r_dl_active_d <= dl_active;
            if (r_dl_active_d && !dl_active) begin
                r_hold_cnt <= c_hold_load;
            end else if (r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
            end

            r_mem_we <= 1'b0;
            if (w_grant_dma) begin
                r_gnt_cpu  <= 1'b0;
                r_ram_ok   <= 1'b1;
                r_mem_addr <= dma_addr;
            end else if (w_grant_cpu) begin
                r_gnt_cpu <= 1'b1;
                r_ram_ok  <= w_cpu_mapped;
                if (w_cpu_mapped) begin
                    r_mem_addr  <= w_cpu_ram_addr;
                    r_mem_we    <= cpu_we & w_cpu_writable;
                    r_mem_wdata <= cpu_wdata;
                end
            end

            if (!dma_req || w_grant_cpu) begin
                r_burst_cnt <= '0;
            end else if (w_grant_dma && cpu_req && !w_burst_full) begin
                r_burst_cnt <= r_burst_cnt + BURST_W'(1);
            end

            if (cpu_ack) begin
                r_cpu_rdata <= w_cpu_rd;
            end
            if (dma_ack) begin
                r_dma_rdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_studio2_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_studio2_mem_arbiter
// Brief    : Self-checking bench for studio2_mem_arbiter with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_studio2_mem_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        dl_active, dl_wr;
    logic [7:0]  dl_index, dl_data;
    logic [11:0] dl_addr;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_hold;
    logic        dma_req;
    logic [11:0] dma_addr;
    logic [7:0]  dma_rdata;
    logic        dma_ack;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [4096];
    bit         ram_written [4096];
    logic [7:0] model_mem [4096];

    always #5 clk_sys = ~clk_sys;

    studio2_mem_arbiter dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .dl_active(dl_active), .dl_wr(dl_wr), .dl_index(dl_index),
        .dl_addr(dl_addr), .dl_data(dl_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .cpu_hold(cpu_hold),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_rdata(dma_rdata),
        .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [7:0] init_val(input int a);
        return 8'((a * 37 + 91) ^ (a >> 4));
    endfunction

    // Synchronous RAM, one-cycle registered read; unwritten cells hold init_val.
    always @(posedge clk_sys) begin
        if (mem_we) begin
            ram[mem_addr]         <= mem_wdata;
            ram_written[mem_addr] <= 1'b1;
        end
        mem_rdata <= ram_written[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
    end

    function automatic logic [11:0] fold(input logic [11:0] a);
        return (a >= 12'hC00 && a < 12'hE00) ? a - 12'h400 : a;
    endfunction

    function automatic bit can_write(input logic [15:0] a);
        return (a >= 16'h0800 && a < 16'h0A00) || (a >= 16'h0C00 && a < 16'h0E00);
    endfunction

    function automatic logic [7:0] exp_read(input logic [15:0] a);
        return (a >= 16'h1000) ? 8'hFF : model_mem[fold(a[11:0])];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic measure_hold(output int n, output bit we_seen);
        n = 0;
        we_seen = 1'b0;
        while (cpu_hold && n < 3000) begin
            @(posedge clk_sys);
            #1;
            n++;
            if (mem_we) we_seen = 1'b1;
        end
    endtask

    task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                              output logic [7:0] rd, output int lat,
                              output logic [11:0] acc_addr, output bit we_seen);
        @(negedge clk_sys);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        lat = 0; rd = 8'h00; acc_addr = 12'h000; we_seen = 1'b0;
        while (lat < 20) begin
            @(negedge clk_sys);
            lat++;
            if (mem_we) we_seen = 1'b1;
            if (lat == 1) acc_addr = mem_addr;
            if (cpu_ack) begin
                rd = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
    endtask

    task automatic dma_access(input logic [11:0] addr, output logic [7:0] rd, output int lat);
        @(negedge clk_sys);
        dma_req = 1'b1; dma_addr = addr; lat = 0; rd = 8'h00;
        while (lat < 20) begin
            @(negedge clk_sys);
            lat++;
            if (dma_ack) begin
                rd = dma_rdata;
                break;
            end
        end
        dma_req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0]  rd;
        logic [11:0] acc;
        bit          wes;
        int          lat, n, n_before, n_after, cyc;
        bit          got_cpu, got;

        for (int i = 0; i < 4096; i++) model_mem[i] = init_val(i);
        reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_index = 8'd0;
        dl_addr = 12'h000; dl_data = 8'h00; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = 16'h0000; cpu_wdata = 8'h00; dma_req = 1'b0; dma_addr = 12'h000;

        // Reset values
        repeat (3) @(negedge clk_sys);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_dma_ack", dma_ack, 0);
        chk("rst_cpu_rdata", cpu_rdata, 8'hFF);
        chk("rst_dma_rdata", dma_rdata, 8'h00);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 12'h000);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        chk("rst_cpu_hold", cpu_hold, 1);

        // Hold after reset release
        reset_n = 1'b1;
        measure_hold(n, wes);
        chk("hold_after_reset", n, 1024);
        chk("hold_no_mem_we", wes, 0);

        // CPU write through the mirror, read back through the base window
        cpu_access(1'b1, 16'h0C23, 8'hA5, rd, lat, acc, wes);
        if (can_write(16'h0C23)) model_mem[fold(12'hC23)] = 8'hA5;
        chk("mirror_wr_lat", lat, 2);
        chk("mirror_wr_addr", acc, 12'h823);
        chk("mirror_wr_we", wes, 1);
        cpu_access(1'b0, 16'h0823, 8'h00, rd, lat, acc, wes);
        chk("mirror_rd_lat", lat, 2);
        chk("mirror_rd_addr", acc, 12'h823);
        chk("mirror_rd_data", rd, 8'hA5);

        // Write-protected ROM and unmapped read
        cpu_access(1'b1, 16'h0100, 8'h77, rd, lat, acc, wes);
        chk("rom_wr_lat", lat, 2);
        chk("rom_wr_no_we", wes, 0);
        cpu_access(1'b0, 16'h1234, 8'h00, rd, lat, acc, wes);
        chk("unmapped_lat", lat, 2);
        chk("unmapped_data", rd, 8'hFF);
        chk("unmapped_no_we", wes, 0);

        // Loader writes, cart offset, overflow drop, hold after download
        @(negedge clk_sys); dl_active = 1'b1;
        repeat (2) @(negedge clk_sys);
        chk("load_hold", cpu_hold, 1);
        dl_index = 8'd1; dl_addr = 12'h010; dl_data = 8'h5A; dl_wr = 1'b1;
        #1;
        chk("load_cart_addr", mem_addr, 12'h410);
        chk("load_cart_we", mem_we, 1);
        chk("load_cart_data", mem_wdata, 8'h5A);
        model_mem[12'h410] = 8'h5A;
        @(negedge clk_sys); dl_wr = 1'b0;
        @(negedge clk_sys); dl_addr = 12'hC00; dl_data = 8'hEE; dl_wr = 1'b1;
        #1;
        chk("load_overflow_drop", mem_we, 0);
        @(negedge clk_sys); dl_wr = 1'b0;
        @(negedge clk_sys); dl_index = 8'd0; dl_addr = 12'h7F0; dl_data = 8'h3C; dl_wr = 1'b1;
        #1;
        chk("load_rom_addr", mem_addr, 12'h7F0);
        chk("load_rom_we", mem_we, 1);
        model_mem[12'h7F0] = 8'h3C;
        @(negedge clk_sys); dl_wr = 1'b0;
        @(negedge clk_sys); dl_active = 1'b0;
        @(posedge clk_sys); #1;
        measure_hold(n, wes);
        chk("hold_after_load", n, 1024);

        // Loader starts while a CPU read is in ACCESS
        @(negedge clk_sys); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0410;
        @(negedge clk_sys);
        chk("abort_access_addr", mem_addr, 12'h410);
        dl_active = 1'b1;
        got = 1'b0;
        repeat (6) begin
            @(negedge clk_sys);
            if (cpu_ack) got = 1'b1;
        end
        chk("abort_no_ack", got, 0);
        dl_active = 1'b0;
        lat = 0; got = 1'b0; rd = 8'h00;
        while (lat < 20 && !got) begin
            @(negedge clk_sys);
            lat++;
            if (cpu_ack) begin got = 1'b1; rd = cpu_rdata; end
        end
        cpu_req = 1'b0;
        chk("reissue_ack", got, 1);
        chk("reissue_data", rd, exp_read(16'h0410));

        // Continuous DMA against a pending CPU read: burst limit
        @(negedge clk_sys);
        dma_req = 1'b1; dma_addr = 12'h7F0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0823;
        n_before = 0; n_after = 0; got_cpu = 1'b0; cyc = 0;
        while (cyc < 200 && n_after == 0) begin
            @(negedge clk_sys);
            cyc++;
            if (dma_ack) begin
                chk("burst_dma_data", dma_rdata, model_mem[12'h7F0]);
                if (got_cpu) n_after++; else n_before++;
            end
            if (cpu_ack) begin
                chk("burst_cpu_data", cpu_rdata, exp_read(16'h0823));
                got_cpu = 1'b1;
                cpu_req = 1'b0;
            end
        end
        dma_req = 1'b0; cpu_req = 1'b0;
        chk("burst_dma_count", n_before, 8);
        chk("burst_cpu_served", got_cpu, 1);
        chk("burst_dma_resumed", n_after, 1);

        // Randomized traffic against the decode model
        for (int k = 0; k < 60; k++) begin
            int          kind;
            logic [15:0] a;
            logic [7:0]  d;
            kind = $urandom_range(0, 3);
            d    = 8'($urandom);
            if (kind == 3) begin
                a = 16'($urandom_range(0, 4095));
                dma_access(a[11:0], rd, lat);
                chk("rnd_dma_lat", lat, 2);
                chk("rnd_dma_data", rd, model_mem[a[11:0]]);
            end else begin
                case ($urandom_range(0, 3))
                    0:       a = 16'($urandom);
                    1:       a = 16'($urandom_range(0, 4095));
                    default: a = 16'h0800 + 16'($urandom_range(0, 16'h05FF));
                endcase
                if (kind == 0) begin
                    cpu_access(1'b1, a, d, rd, lat, acc, wes);
                    chk("rnd_wr_lat", lat, 2);
                    chk("rnd_wr_we", wes, can_write(a));
                    if (a < 16'h1000) chk("rnd_wr_addr", acc, fold(a[11:0]));
                    if (can_write(a)) model_mem[fold(a[11:0])] = d;
                end else begin
                    cpu_access(1'b0, a, 8'h00, rd, lat, acc, wes);
                    chk("rnd_rd_lat", lat, 2);
                    chk("rnd_rd_data", rd, exp_read(a));
                    chk("rnd_rd_no_we", wes, 0);
                    if (a < 16'h1000) chk("rnd_rd_addr", acc, fold(a[11:0]));
                end
            end
        end

        repeat (2) @(negedge clk_sys);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
